// File: rtl/round.sv
// Lap tracker for a circular FIFO: one state bit records whether the write
// pointer has wrapped once more than the read pointer, resolving full vs empty.
module round #(
  parameter int BufferWidth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Push,
  input  logic                   Pop,
  input  logic [BufferWidth-1:0] W_Addr,
  input  logic [BufferWidth-1:0] R_Addr,
  output logic                   Round,
  output logic                   Full,
  output logic                   Empty
);

  localparam logic [BufferWidth-1:0] LAST = '1;

  logic r_round;
  logic w_same_addr;
  logic w_wr_ok;
  logic w_rd_ok;
  logic w_wr_wrap;
  logic w_rd_wrap;

  // Flags use the pre-edge lap bit, so a pop never frees room for a push in the same cycle.
  assign w_same_addr = (W_Addr == R_Addr);
  assign Full        = r_round & w_same_addr;
  assign Empty       = ~r_round & w_same_addr;
  assign w_wr_ok     = Push & ~Full;
  assign w_rd_ok     = Pop & ~Empty;
  assign w_wr_wrap   = w_wr_ok & (W_Addr == LAST);
  assign w_rd_wrap   = w_rd_ok & (R_Addr == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_round <= 1'b0;
    else     r_round <= r_round ^ w_wr_wrap ^ w_rd_wrap;
  end

  assign Round = r_round;

endmodule

// File: tb/tb_round.sv
// Directed bench for round: a vector table walked in order (state carries
// between rows) followed by a full fill/drain of a 16-entry FIFO.
module tb_round;

  logic       clk = 1'b0;
  logic       rst;
  logic       Push;
  logic       Pop;
  logic [3:0] W_Addr;
  logic [3:0] R_Addr;
  logic       Round;
  logic       Full;
  logic       Empty;

  int checks = 0;
  int errors = 0;

  round #(.BufferWidth(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .Push   (Push),
    .Pop    (Pop),
    .W_Addr (W_Addr),
    .R_Addr (R_Addr),
    .Round  (Round),
    .Full   (Full),
    .Empty  (Empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       push;
    logic       pop;
    logic [3:0] w;
    logic [3:0] r;
    logic       chk_flags;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_round;
  } vec_t;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    vec_t vecs[17];
    int   wp;
    int   rp;
    int   cnt;

    //            rst  push pop  w      r      chk  full empty round_after
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd15, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd15, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd15, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1};
    // Full at LAST: push blocked, pop wraps alone.
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0};
    // Empty at LAST: pop blocked, push wraps alone.
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'd15, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'd15, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 4'd3,  4'd3,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 4'd3,  4'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd15, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 4'd15, 4'd2,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 4'd15, 4'd2,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 4'd5,  4'd5,  1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b0; Push = 1'b0; Pop = 1'b0; W_Addr = '0; R_Addr = '0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; Push = vecs[i].push; Pop = vecs[i].pop;
      W_Addr = vecs[i].w; R_Addr = vecs[i].r;
      #1;
      if (vecs[i].chk_flags) begin
        check($sformatf("vec%0d full", i),  Full,  vecs[i].exp_full);
        check($sformatf("vec%0d empty", i), Empty, vecs[i].exp_empty);
      end
      @(posedge clk);
      #1;
      check($sformatf("vec%0d round", i), Round, vecs[i].exp_round);
    end

    // Fill then drain a 16-entry FIFO; the bench owns the pointers and an
    // occupancy count that defines the expected flags.
    @(negedge clk);
    rst = 1'b1; Push = 1'b0; Pop = 1'b0; W_Addr = 4'd9; R_Addr = 4'd9;
    @(negedge clk);
    rst = 1'b0;
    wp = 9; rp = 9; cnt = 0;
    for (int k = 0; k < 34; k++) begin
      Push = (k < 17);
      Pop  = (k >= 17);
      W_Addr = 4'(wp); R_Addr = 4'(rp);
      #1;
      check($sformatf("fill%0d full", k),  Full,  cnt == 16);
      check($sformatf("fill%0d empty", k), Empty, cnt == 0);
      if (Push && cnt < 16) begin cnt++; wp = (wp + 1) % 16; end
      if (Pop && cnt > 0)   begin cnt--; rp = (rp + 1) % 16; end
      @(negedge clk);
    end
    W_Addr = 4'(wp); R_Addr = 4'(rp); Push = 1'b0; Pop = 1'b0;
    #1;
    check("drain empty", Empty, 1'b1);
    check("drain round", Round, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
